// File: rtl/noise_pkg.sv
// Shared types, constants and LFSR helper functions for the multi-channel noise generator.
package noise_pkg;

    localparam int LFSR_W = 32;
    localparam logic [LFSR_W-1:0] LFSR_TAPS      = 32'h8020_0003;
    localparam logic [LFSR_W-1:0] CH_SEED_STRIDE = 32'h9E37_79B9;

    typedef enum logic [1:0] {
        IDLE,
        DRAW_A,
        DRAW_B,
        PRESENT
    } state_t;

    // Galois right-shift step; returns {output bit, next state}. inject is XORed into the feedback bit.
    function automatic logic [LFSR_W:0] lfsr_step(input logic [LFSR_W-1:0] s, input logic inject);
        logic              fb;
        logic [LFSR_W-1:0] nxt;
        fb  = s[0] ^ inject;
        nxt = s >> 1;
        if (fb) nxt = nxt ^ LFSR_TAPS;
        if (nxt == '0) nxt = {{(LFSR_W-1){1'b0}}, 1'b1};
        return {fb, nxt};
    endfunction

    function automatic logic [LFSR_W-1:0] derive_seed(input logic [LFSR_W-1:0] seed, input int unsigned ch);
        logic [LFSR_W-1:0] d;
        d = seed ^ (LFSR_W'(ch) * CH_SEED_STRIDE);
        if (d == '0) d = {{(LFSR_W-1){1'b0}}, 1'b1};
        return d;
    endfunction

endpackage

// File: rtl/noise_if.sv
// Valid/ready sample-set channel from the noise generator to the mixer/dither stage.
interface noise_if #(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 16
);
    logic [CHANNELS*SAMPLE_W-1:0] noise_data;
    logic                         noise_valid;
    logic                         noise_ready;

    modport master (output noise_data, output noise_valid, input  noise_ready);
    modport slave  (input  noise_data, input  noise_valid, output noise_ready);
endinterface

// File: rtl/noise_lfsr.sv
// One noise channel: seeded LFSR, bit accumulator, first-draw register and triangular combiner.
module noise_lfsr
    import noise_pkg::*;
#(
    parameter int                SAMPLE_W = 16,
    parameter int unsigned       CH       = 0,
    parameter logic [LFSR_W-1:0] SEED     = 32'hACE1_1234
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                seed_load,
    input  logic [LFSR_W-1:0]   seed,
    input  logic                step,
    input  logic                save_a,
    input  logic                load_data,
    input  logic                tri_mode,
    input  logic                inject,
    output logic [SAMPLE_W-1:0] sample
);
    logic [LFSR_W-1:0]   lfsr_reg;
    logic [SAMPLE_W-1:0] acc_reg;
    logic [SAMPLE_W-1:0] a_reg;
    logic [SAMPLE_W-1:0] data_reg;
    logic [LFSR_W:0]     step_res;
    logic [SAMPLE_W-1:0] acc_next;
    logic [SAMPLE_W-1:0] tri_res;
    logic                unused_tri_lsb;

    assign step_res = lfsr_step(lfsr_reg, inject);
    assign acc_next = {acc_reg[SAMPLE_W-2:0], step_res[LFSR_W]};

    // Sign-extended sum at SAMPLE_W+1 bits; dropping the LSB is the arithmetic shift by one.
    assign {tri_res, unused_tri_lsb} = {a_reg[SAMPLE_W-1], a_reg} + {acc_reg[SAMPLE_W-1], acc_reg};

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            lfsr_reg <= derive_seed(SEED, CH);
            acc_reg  <= '0;
            a_reg    <= '0;
            data_reg <= '0;
        end else if (seed_load) begin
            lfsr_reg <= derive_seed(seed, CH);
            acc_reg  <= '0;
        end else begin
            if (step) begin
                lfsr_reg <= step_res[LFSR_W-1:0];
                acc_reg  <= acc_next;
            end
            if (save_a) a_reg <= acc_next;
            if (load_data) data_reg <= tri_mode ? tri_res : acc_reg;
        end
    end

    assign sample = data_reg;

endmodule

// File: rtl/noise_generator.sv
// Multi-channel LFSR noise source with uniform/triangular modes and a valid/ready output.
// Define NOISE_ENTROPY_EN to XOR entropy_bit into every channel's LFSR feedback.
module noise_generator
    import noise_pkg::*;
#(
    parameter int                CHANNELS = 2,
    parameter int                SAMPLE_W = 16,
    parameter logic [LFSR_W-1:0] SEED     = 32'hACE1_1234
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              enable,
    input  logic              sample_tick,
    input  logic              mode,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              entropy_bit,
    noise_if.master           bus,
    output logic              overrun,
    input  logic              clear_overrun
);
    localparam int CNT_W = (SAMPLE_W > 2) ? $clog2(SAMPLE_W) : 1;

    state_t                     state_reg, state_next;
    logic [CNT_W-1:0]           cnt_reg, cnt_next;
    logic                       mode_reg;
    logic                       valid_reg;
    logic                       overrun_reg;
    logic                       run, last, accept, drop, handshake;
    logic                       step, save_a, load_data, inject;
    logic [CHANNELS*SAMPLE_W-1:0] data_flat;

`ifdef NOISE_ENTROPY_EN
    assign inject = entropy_bit;
`else
    logic unused_entropy;
    assign inject         = 1'b0;
    assign unused_entropy = entropy_bit;
`endif

    assign run       = enable & ~seed_load;
    assign last      = (cnt_reg == CNT_W'(SAMPLE_W-1));
    assign handshake = valid_reg & bus.noise_ready;
    // A tick is taken only when the previous set is gone or leaving this very cycle.
    assign accept    = sample_tick & run & (state_reg == IDLE) & (~valid_reg | handshake);
    assign drop      = sample_tick & run & ~accept;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = (step && !last) ? cnt_reg + 1'b1 : '0;
        if (!run) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (accept) state_next = DRAW_A;
                DRAW_A:  if (last) state_next = mode_reg ? DRAW_B : PRESENT;
                DRAW_B:  if (last) state_next = PRESENT;
                PRESENT: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        step      = 1'b0;
        save_a    = 1'b0;
        load_data = 1'b0;
        if (run) begin
            step      = (state_reg == DRAW_A) || (state_reg == DRAW_B);
            save_a    = (state_reg == DRAW_A) && last && mode_reg;
            load_data = (state_reg == PRESENT);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cnt_reg     <= '0;
            mode_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            if (accept) mode_reg <= mode;
            if (!run)           valid_reg <= 1'b0;
            else if (load_data) valid_reg <= 1'b1;
            else if (handshake) valid_reg <= 1'b0;
            if (drop)               overrun_reg <= 1'b1;
            else if (clear_overrun) overrun_reg <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            noise_lfsr #(
                .SAMPLE_W (SAMPLE_W),
                .CH       (gi),
                .SEED     (SEED)
            ) u_lfsr (
                .CLOCK_50  (CLOCK_50),
                .resetn    (resetn),
                .seed_load (seed_load),
                .seed      (seed),
                .step      (step),
                .save_a    (save_a),
                .load_data (load_data),
                .tri_mode  (mode_reg),
                .inject    (inject),
                .sample    (data_flat[gi*SAMPLE_W +: SAMPLE_W])
            );
        end
    endgenerate

    assign bus.noise_data  = data_flat;
    assign bus.noise_valid = valid_reg;
    assign overrun         = overrun_reg;

endmodule
